external_synchronizer: RTL and testbench
========================================

Name: external_synchronizer

Overview:
- Multi-bit, bit-independent flip-flop chain synchronizer that brings asynchronous external signals (pins, other clock domains) into the clk domain.
- Each bit of data_in passes through its own chain of STAGES flip-flops.
- Intended for quasi-static or level signals only. It gives no multi-bit coherency guarantee; bus values need a handshake or FIFO instead.

Parameters:
- DATA_WIDTH, 32, number of independent bits synchronized; legal range ≥1.
- STAGES, 2, flip-flops per bit; legal range ≥2. Elaboration error if STAGES<2.
- RESET_VALUE, '0 (DATA_WIDTH bits), value loaded into every stage of the chain while reset is asserted.

Ports:
- clk, input, 1, destination-domain clock; all flops sample on the rising edge.
- reset, input, 1, asynchronous active-low reset. Assertion is immediate; deassertion must be synchronous to clk at system level.
- data_in, input, DATA_WIDTH, asynchronous external input. A narrower signal connected here is zero-extended by the connection.
- data_out, output, DATA_WIDTH, synchronized copy of data_in; driven directly from the last flop stage, with no combinational logic after it.

Behaviour:
- Reset (reset=0): all stages of all bits take RESET_VALUE immediately, without waiting for clk. data_out=RESET_VALUE while reset is held.
- Normal operation: on each rising edge of clk, stage[0] captures data_in and stage[k] captures stage[k-1]. data_out = stage[STAGES-1].
- Latency: a data_in change that is stable before rising edge N appears on data_out after edge N+STAGES-1. With STAGES=2 it appears after the 2nd edge, so data_out matches within 2 clk periods.
- If data_in changes inside the setup/hold window, add at most one further edge of uncertainty. data_out never shows an intermediate or metastable value at the module boundary.
- Bits are fully independent. A simultaneous change on several bits may land on data_out in different cycles, differing by at most 1 cycle.
- Pulses shorter than one clk period may be lost. This is permitted and not an error.
- Reset asserted mid-operation aborts all in-flight values; every stage returns to RESET_VALUE.
- After reset deassertion, the first real data_in value appears STAGES edges later.
- No enable, no handshake; the chain advances on every clk edge.
- Synthesis attributes: mark stage flops ASYNC_REG or the equivalent, keep them adjacent, and do not retime them.

Optional Feature:
- Macro EXT_SYNC_EDGE_EN.
- When defined, adds two extra outputs, rise_out and fall_out, each DATA_WIDTH wide.
  - rise_out[i]=1 for exactly one clk cycle when data_out[i] goes 0→1.
  - fall_out[i]=1 for exactly one clk cycle when data_out[i] goes 1→0.
  - Both are derived from one extra registered copy of data_out; that register resets to RESET_VALUE, so no edge is flagged on reset release.
  - Both outputs are 0 during reset.
- When undefined: these ports and the extra register do not exist, and behaviour is identical to the base block.

Decomposition:
- Shared package ext_sync_pkg holds:
  - localparam EXT_SYNC_MIN_STAGES=2;
  - default width constant EXT_SYNC_DEF_WIDTH=32.
- One sub-module sync_bit_chain: 1-bit, STAGES-deep flop chain with an async active-low reset to a 1-bit reset value. The top module instantiates it DATA_WIDTH times in a generate loop.

Test Plan:
- Reset: hold reset=0 for 3 clk with data_in=32'hFFFFFFFF → data_out=32'h0 throughout. After release, data_out=32'hFFFFFFFF on the 2nd rising edge.
- Walking bit: data_in=$random value V; for i=0..31 drive data_in={31'b0,V[i]} and wait 2 clk → data_out equals the zero-extended V[i] every step.
- Latency exactness: with STAGES=3, toggle bit 5 from 0 to 1 mid-cycle → data_out[5] is still 0 after 2 edges and 1 after 3 edges.
- Async reset mid-stream: data_out=32'hA5A5A5A5, assert reset between edges → data_out=RESET_VALUE immediately, before the next clk edge.
- Edge feature (EXT_SYNC_EDGE_EN): data_in[0] 0→1→0 with each level held 4 clk → rise_out[0] and fall_out[0] each pulse high exactly 1 cycle, aligned with the data_out transition. No pulses after reset release.
- Short pulse: 2 ns glitch on data_in[3] between edges → data_out[3] stays 0 with no X on the output; the bench flags any X.

Source files
------------

// File: rtl/ext_sync_pkg.sv
// Shared constants for the external signal synchronizer and its per-bit chain.
package ext_sync_pkg;

  localparam int EXT_SYNC_MIN_STAGES = 2;
  localparam int EXT_SYNC_DEF_WIDTH  = 32;

endpackage

// File: rtl/sync_bit_chain.sv
// One-bit flop chain synchronizer, STAGES deep, asynchronous active-low reset.
module sync_bit_chain
  import ext_sync_pkg::*;
#(
  parameter int   STAGES      = EXT_SYNC_MIN_STAGES,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < EXT_SYNC_MIN_STAGES) begin : g_stages_check
    $error("sync_bit_chain: STAGES must be at least %0d", EXT_SYNC_MIN_STAGES);
  end

  // Stage 0 is the LSB; keep these flops together and out of retiming.
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE" *)
  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= {STAGES{RESET_VALUE}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/external_synchronizer.sv
// Bit-independent multi-bit synchronizer for quasi-static external inputs.
// Optional edge-detect outputs rise_out/fall_out are enabled by EXT_SYNC_EDGE_EN.
module external_synchronizer
  import ext_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH  = EXT_SYNC_DEF_WIDTH,
  parameter int                    STAGES      = EXT_SYNC_MIN_STAGES,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef EXT_SYNC_EDGE_EN
  output logic [DATA_WIDTH-1:0] rise_out,
  output logic [DATA_WIDTH-1:0] fall_out,
`endif
  output logic [DATA_WIDTH-1:0] data_out
);

  if (STAGES < EXT_SYNC_MIN_STAGES) begin : g_stages_check
    $error("external_synchronizer: STAGES must be at least %0d", EXT_SYNC_MIN_STAGES);
  end

  // No coherency across bits: each bit resolves on its own chain.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    sync_bit_chain #(
      .STAGES      (STAGES),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_chain (
      .clk   (clk),
      .reset (reset),
      .d     (data_in[i]),
      .q     (data_out[i])
    );
  end

`ifdef EXT_SYNC_EDGE_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] prev_d;

  always_comb begin
    prev_d = data_out;
  end

  // Resetting to RESET_VALUE keeps reset release from looking like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= RESET_VALUE;
    end else begin
      prev_q <= prev_d;
    end
  end

  always_comb begin
    rise_out = data_out & ~prev_q;
    fall_out = ~data_out & prev_q;
  end
`else
  // Base build: data_out is the only output.
`endif

endmodule

// File: tb/tb_external_synchronizer.sv
// Directed bench for external_synchronizer: a default 2-stage instance and a
// 3-stage instance with a non-zero reset value share the same stimulus.
module tb_external_synchronizer;
   import ext_sync_pkg::*;

   localparam int             W   = EXT_SYNC_DEF_WIDTH;
   localparam logic [W-1:0]   RV3 = 32'h0000_00F0;

   logic         clk;
   logic         reset;
   logic [W-1:0] data_in;
   logic [W-1:0] out2;
   logic [W-1:0] out3;
`ifdef EXT_SYNC_EDGE_EN
   logic [W-1:0] rise2, fall2, rise3, fall3;
`endif

   int checks = 0;
   int errors = 0;

   external_synchronizer u_dut2 (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
`ifdef EXT_SYNC_EDGE_EN
      .rise_out (rise2),
      .fall_out (fall2),
`endif
      .data_out (out2)
   );

   external_synchronizer #(
      .DATA_WIDTH  (W),
      .STAGES      (3),
      .RESET_VALUE (RV3)
   ) u_dut3 (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
`ifdef EXT_SYNC_EDGE_EN
      .rise_out (rise3),
      .fall_out (fall3),
`endif
      .data_out (out3)
   );

   // Free-running 100 MHz clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Change data_in mid-cycle, well clear of the sampling edge.
   task automatic applyStimulus(input logic [W-1:0] v);
      @(negedge clk);
      data_in = v;
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Linear directed sequence; every expected value is hand-derived from the
   // chain depth of each instance.
   initial begin
      logic [W-1:0] v;
      logic [W-1:0] nv;
      logic [W-1:0] prev;

      reset   = 1'b1;
      data_in = '1;
      #2 reset = 1'b0;
      #1;
      $display("[TB] reset phase");
      checkOutput("reset_async_s2", out2, '0);
      checkOutput("reset_async_s3", out3, RV3);
`ifdef EXT_SYNC_EDGE_EN
      checkOutput("reset_rise_s2", rise2, '0);
      checkOutput("reset_fall_s3", fall3, '0);
`endif
      for (int k = 0; k < 3; k++) begin
         step(1);
         checkOutput("reset_hold_s2", out2, '0);
         checkOutput("reset_hold_s3", out3, RV3);
      end

      @(negedge clk);
      reset = 1'b1;
      step(1);
      checkOutput("release_e1_s2", out2, '0);
`ifdef EXT_SYNC_EDGE_EN
      checkOutput("release_e1_rise", rise2, '0);
      checkOutput("release_e1_fall", fall2, '0);
      checkOutput("release_e1_fall3", fall3, '0);
`endif
      step(1);
      checkOutput("release_e2_s2", out2, '1);
      checkOutput("release_e2_s3", out3, RV3);
      step(1);
      checkOutput("release_e3_s2", out2, '1);
      checkOutput("release_e3_s3", out3, '1);

      $display("[TB] walking bit");
      v    = $urandom;
      prev = '1;
      for (int i = 0; i < W; i++) begin
         nv    = '0;
         nv[0] = v[i];
         applyStimulus(nv);
         step(1);
         checkOutput("walk_e1_s2", out2, prev);
         step(1);
         checkOutput("walk_e2_s2", out2, nv);
         checkOutput("walk_e2_s3", out3, prev);
         step(1);
         checkOutput("walk_e3_s3", out3, nv);
         prev = nv;
      end

      $display("[TB] latency");
      applyStimulus('0);
      step(3);
      applyStimulus(32'h0000_0020);
      step(2);
      checkOutput("lat_e2_s2", out2, 32'h0000_0020);
      checkOutput("lat_e2_s3", out3, '0);
      step(1);
      checkOutput("lat_e3_s3", out3, 32'h0000_0020);

      $display("[TB] async reset mid-stream");
      applyStimulus(32'hA5A5_A5A5);
      step(3);
      checkOutput("mid_pre_s2", out2, 32'hA5A5_A5A5);
      checkOutput("mid_pre_s3", out3, 32'hA5A5_A5A5);
      #3 reset = 1'b0;
      #1;
      checkOutput("mid_async_s2", out2, '0);
      checkOutput("mid_async_s3", out3, RV3);
`ifdef EXT_SYNC_EDGE_EN
      checkOutput("mid_async_rise", rise2, '0);
      checkOutput("mid_async_fall", fall2, '0);
`endif
      step(2);
      checkOutput("mid_hold_s2", out2, '0);
      checkOutput("mid_hold_s3", out3, RV3);
      @(negedge clk);
      reset = 1'b1;
      step(1);
      checkOutput("mid_rel_e1_s2", out2, '0);
      step(1);
      checkOutput("mid_rel_e2_s2", out2, 32'hA5A5_A5A5);
      checkOutput("mid_rel_e2_s3", out3, RV3);
      step(1);
      checkOutput("mid_rel_e3_s3", out3, 32'hA5A5_A5A5);

      $display("[TB] short glitch");
      applyStimulus('0);
      step(3);
      #1 data_in[3] = 1'b1;
      #2 data_in[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1);
         checkOutput("glitch_s2", out2, '0);
         checkOutput("glitch_s3", out3, '0);
      end

`ifdef EXT_SYNC_EDGE_EN
      $display("[TB] edge outputs");
      applyStimulus(32'h1);
      step(1);
      checkOutput("rise_e1", rise2, '0);
      step(1);
      checkOutput("rise_e2", rise2, 32'h1);
      checkOutput("rise_e2_fall", fall2, '0);
      step(1);
      checkOutput("rise_e3", rise2, '0);
      step(1);
      checkOutput("rise_e4", rise2, '0);
      applyStimulus('0);
      step(1);
      checkOutput("fall_e1", fall2, '0);
      step(1);
      checkOutput("fall_e2", fall2, 32'h1);
      checkOutput("fall_e2_rise", rise2, '0);
      step(1);
      checkOutput("fall_e3", fall2, '0);
      checkOutput("fall_e3_s3", fall3, 32'h1);
      step(1);
      checkOutput("fall_e4", fall2, '0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
